align_accumulator: RTL



---
 rtl/sd4_mac_pkg.sv | 21 ++
 rtl/align_shifter.sv | 21 ++
 rtl/align_accumulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/sd4_mac_pkg.sv
// Shared widths, saturation constants and FSM state type for the SD4 MAC
// alignment/accumulate datapath.
package sd4_mac_pkg;

  localparam int unsigned SUM_W     = 20;
  localparam int unsigned EXP_W     = 6;
  localparam int unsigned MANT_W    = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned SHIFT_SAT = 19;

  localparam logic [SUM_W-1:0] SAT_POS = 20'h7FFFF;
  localparam logic [SUM_W-1:0] SAT_NEG = 20'h80000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

endpackage

// File: rtl/align_shifter.sv
// Combinational arithmetic right shift of the alignment operand; the shift
// amount saturates at SHIFT_SAT so large exponent gaps collapse to 0 or -1.
module align_shifter
  import sd4_mac_pkg::*;
(
  input  logic signed [SUM_W-1:0] operand,
  input  logic        [EXP_W:0]   amount,
  output logic signed [SUM_W-1:0] result_c
);

  logic [SHIFT_W-1:0] sh;

  always_comb begin
    sh = amount[SHIFT_W-1:0];
    if (amount > (EXP_W+1)'(SHIFT_SAT)) begin
      sh = SHIFT_W'(SHIFT_SAT);
    end
    result_c = operand >>> sh;
  end

endmodule

// File: rtl/align_accumulator.sv
// Aligns a stream of signed product terms to a running maximum exponent and
// accumulates them, presenting the group sum over a valid/ready handshake.
module align_accumulator
  import sd4_mac_pkg::*;
#(
  parameter int unsigned N_MAX = 16
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic        [MANT_W-1:0] prod_mant,
  input  logic        [EXP_W-1:0]  prod_exp,
  input  logic                     prod_last,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic signed [SUM_W-1:0]  signed_sum,
  output logic        [EXP_W-1:0]  exp_max,
  output logic        [CNT_W-1:0]  term_cnt,
  output logic                     ovf
);

  acc_state_t state;

  logic                    fire;
  logic signed [SUM_W-1:0] mant_ext;
  logic        [EXP_W:0]   d;
  logic                    d_pos;
  logic        [EXP_W:0]   amount;
  logic signed [SUM_W-1:0] shift_in;
  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] add_a;
  logic signed [SUM_W-1:0] add_b;
  logic signed [SUM_W-1:0] raw_sum;
  logic                    add_ovf;
  logic signed [SUM_W-1:0] sat_sum;

  assign fire     = prod_valid && prod_ready;
  assign mant_ext = {{(SUM_W-MANT_W){prod_mant[MANT_W-1]}}, prod_mant};

  // Exponent gap at one extra bit so -32 - 31 cannot wrap.
  assign d      = {prod_exp[EXP_W-1], prod_exp} - {exp_max[EXP_W-1], exp_max};
  assign d_pos  = !d[EXP_W] && (d != '0);
  assign amount = d_pos ? d : -d;

  // Shift whichever side has the smaller exponent.
  assign shift_in = d_pos ? signed_sum : mant_ext;

  align_shifter u_shifter (
    .operand  (shift_in),
    .amount   (amount),
    .result_c (shifted)
  );

  assign add_a   = d_pos ? shifted  : signed_sum;
  assign add_b   = d_pos ? mant_ext : shifted;
  assign raw_sum = add_a + add_b;
  assign add_ovf = (add_a[SUM_W-1] == add_b[SUM_W-1]) &&
                   (raw_sum[SUM_W-1] != add_a[SUM_W-1]);
  assign sat_sum = add_ovf ? (add_a[SUM_W-1] ? SAT_NEG : SAT_POS) : raw_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      signed_sum <= '0;
      exp_max    <= '0;
      term_cnt   <= '0;
      ovf        <= 1'b0;
      prod_ready <= 1'b1;
      sum_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            signed_sum <= mant_ext;
            exp_max    <= prod_exp;
            term_cnt   <= CNT_W'(1);
            ovf        <= 1'b0;
            state      <= prod_last ? HOLD : ACC;
            prod_ready <= !prod_last;
            sum_valid  <= prod_last;
          end
        end
        ACC: begin
          if (fire) begin
            signed_sum <= sat_sum;
            if (d_pos) begin
              exp_max <= prod_exp;
            end
            if (term_cnt != '1) begin
              term_cnt <= term_cnt + CNT_W'(1);
            end
            ovf        <= ovf || add_ovf || (term_cnt >= CNT_W'(N_MAX));
            state      <= prod_last ? HOLD : ACC;
            prod_ready <= !prod_last;
            sum_valid  <= prod_last;
          end
        end
        HOLD: begin
          if (sum_ready) begin
            signed_sum <= '0;
            exp_max    <= '0;
            term_cnt   <= '0;
            state      <= IDLE;
            prod_ready <= 1'b1;
            sum_valid  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          prod_ready <= 1'b1;
          sum_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
